// File: rtl/averager_pkg.sv
// rtl/averager_pkg.sv - shared defaults, address helper and readout state encoding for the averager
package averager_pkg;

    localparam int DEFAULT_FAST_COUNT_WIDTH = 13;
    localparam int SLOW_COUNT_WIDTH         = 19;
    localparam int ADDR_LSB                 = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/averager_reader_fifo.sv
// rtl/averager_reader_fifo.sv - synchronous prefetch FIFO with a registered output word
module averager_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       out_valid_o,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH)+1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      mcnt_q, mcnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             load_out, take, bypass, mem_we;

    // The output register is refilled from memory first; an empty memory lets a push bypass straight in.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mcnt_d      = mcnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        load_out    = !out_valid_q || pop_i;
        take        = load_out && (mcnt_q != '0);
        bypass      = load_out && (mcnt_q == '0) && push_i;
        mem_we      = push_i && !bypass;
        if (take) begin
            out_data_d  = mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + AW'(1);
        end else if (bypass) begin
            out_data_d  = push_data_i;
            out_valid_d = 1'b1;
        end else if (load_out) begin
            out_valid_d = 1'b0;
        end
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        mcnt_d = mcnt_q + (AW+1)'(mem_we) - (AW+1)'(take);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mcnt_q      <= mcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign count_o     = {1'b0, mcnt_q} + (AW+2)'(out_valid_q);

endmodule

// File: rtl/averager_reader.sv
// rtl/averager_reader.sv - reads accumulated sums from BRAM port B, normalises them and streams one frame
module averager_reader
    import averager_pkg::*;
#(
    parameter int FAST_COUNT_WIDTH = DEFAULT_FAST_COUNT_WIDTH,
    parameter int DATA_WIDTH       = 32,
    parameter int SHIFT_WIDTH      = 5,
    parameter int READ_LATENCY     = 2,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [FAST_COUNT_WIDTH-1:0]        count_max,
    input  logic [SHIFT_WIDTH-1:0]             shift,
    input  logic [SLOW_COUNT_WIDTH-1:0]        n_avg,
    output logic                               busy,
    output logic                               done,
    output logic [SLOW_COUNT_WIDTH-1:0]        n_avg_out,
    output logic [FAST_COUNT_WIDTH+ADDR_LSB-1:0] bram_addr,
    output logic                               bram_en,
    input  logic [DATA_WIDTH-1:0]              bram_rddata,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic                               m_axis_tlast
);

    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 3;

    rd_state_e                    state_q, state_d;
    logic [FAST_COUNT_WIDTH-1:0]  rd_idx_q, rd_idx_d;
    logic [FAST_COUNT_WIDTH-1:0]  land_idx_q, land_idx_d;
    logic [FAST_COUNT_WIDTH-1:0]  count_max_q, count_max_d;
    logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
    logic [SLOW_COUNT_WIDTH-1:0]  n_avg_q, n_avg_d;
    logic [READ_LATENCY-1:0]      vld_q, vld_d;
    logic                         done_q, done_d;

    logic [FAW+1:0]               fifo_count;
    logic [DATA_WIDTH:0]          fifo_out;
    logic [DATA_WIDTH:0]          push_data;
    logic                         fifo_valid;
    logic                         fifo_last;
    logic [CW-1:0]                inflight;
    logic [CW-1:0]                occupancy;
    logic                         credit;
    logic                         pop;
    logic                         land;
    logic signed [DATA_WIDTH-1:0] shifted;

    assign pop       = fifo_valid && m_axis_tready;
    assign fifo_last = fifo_out[DATA_WIDTH];
    assign land      = vld_q[READ_LATENCY-1];
    assign shifted   = $signed(bram_rddata) >>> shift_q;
    assign push_data = {(land_idx_q == count_max_q), shifted};

    // A slot freed by this cycle's pop can be reused: the new read lands at least one cycle later.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
        occupancy = inflight + CW'(fifo_count) - CW'(pop);
        credit    = occupancy < CW'(FIFO_DEPTH);
        bram_en   = (state_q == ST_READ) && credit;
    end

    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        land_idx_d  = land_idx_q;
        count_max_d = count_max_q;
        shift_d     = shift_q;
        n_avg_d     = n_avg_q;
        done_d      = 1'b0;
        vld_d       = '0;
        vld_d[0]    = bram_en;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        if (land) begin
            land_idx_d = land_idx_q + FAST_COUNT_WIDTH'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_max_d = count_max;
                    shift_d     = shift;
                    n_avg_d     = n_avg;
                    rd_idx_d    = '0;
                    land_idx_d  = '0;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                if (bram_en) begin
                    if (rd_idx_q == count_max_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        rd_idx_d = rd_idx_q + FAST_COUNT_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_idx_q    <= '0;
            land_idx_q  <= '0;
            count_max_q <= '0;
            shift_q     <= '0;
            n_avg_q     <= '0;
            vld_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            land_idx_q  <= land_idx_d;
            count_max_q <= count_max_d;
            shift_q     <= shift_d;
            n_avg_q     <= n_avg_d;
            vld_q       <= vld_d;
            done_q      <= done_d;
        end
    end

    averager_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (land),
        .push_data_i (push_data),
        .pop_i       (pop),
        .out_valid_o (fifo_valid),
        .out_data_o  (fifo_out),
        .count_o     (fifo_count)
    );

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign n_avg_out     = n_avg_q;
    assign bram_addr     = {rd_idx_q, {ADDR_LSB{1'b0}}};
    assign m_axis_tvalid = fifo_valid;
    assign m_axis_tdata  = fifo_out[DATA_WIDTH-1:0];
    // The stored last flag outlives the beat, so it is only shown alongside tvalid.
    assign m_axis_tlast  = fifo_valid && fifo_last;

endmodule

// File: tb/tb_averager_reader.sv
// tb/tb_averager_reader.sv - scoreboard bench for averager_reader with a BRAM model and random backpressure
module tb_averager_reader;

    localparam int FCW = 13;
    localparam int DW  = 32;
    localparam int SW  = 5;
    localparam int RL  = 2;
    localparam int FD  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [FCW-1:0] count_max;
    logic [SW-1:0]  shift;
    logic [18:0]    n_avg;
    logic           busy;
    logic           done;
    logic [18:0]    n_avg_out;
    logic [FCW+1:0] bram_addr;
    logic           bram_en;
    logic [DW-1:0]  bram_rddata;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tlast;

    always #5 clk = ~clk;

    averager_reader #(
        .FAST_COUNT_WIDTH (FCW),
        .DATA_WIDTH       (DW),
        .SHIFT_WIDTH      (SW),
        .READ_LATENCY     (RL),
        .FIFO_DEPTH       (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .count_max     (count_max),
        .shift         (shift),
        .n_avg         (n_avg),
        .busy          (busy),
        .done          (done),
        .n_avg_out     (n_avg_out),
        .bram_addr     (bram_addr),
        .bram_en       (bram_en),
        .bram_rddata   (bram_rddata),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    // BRAM port B: two-cycle read latency; unrequested reads return a marker value.
    logic [DW-1:0] mem [0:8191];
    logic [DW-1:0] bram_s1;
    always @(posedge clk) begin
        bram_s1     <= bram_en ? mem[bram_addr[FCW+1:2]] : 32'hDEAD_BEEF;
        bram_rddata <= bram_s1;
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    rand_ready = 1'b0;

    int    cyc = 0, start_cyc = 0, first_tv_cyc = -1, first_hs_cyc = -1, last_hs_cyc = -1;
    int    issued = 0, accepted = 0, max_out = 0, beats = 0, done_count = 0, max_addr = 0;
    bit    done_flag = 1'b0, last_hs_prev = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic  prev_last;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and watches the AXI and done rules.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall   = 1'b0;
            last_hs_prev = 1'b0;
        end else begin
            if (start && !busy) start_cyc = cyc;
            if (bram_en) begin
                issued++;
                if (int'(bram_addr) > max_addr) max_addr = int'(bram_addr);
            end
            if (m_axis_tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
            if (prev_stall) begin
                chk(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last,
                    "stall_stable", $signed(m_axis_tdata), $signed(prev_data));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                accepted++;
                beats++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                if (m_axis_tlast) last_hs_cyc = cyc;
                chk(exp_q.size() > 0, "beat_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk(m_axis_tdata == b.d, "tdata", $signed(m_axis_tdata), $signed(b.d));
                    chk(m_axis_tlast == b.l, "tlast", m_axis_tlast, b.l);
                end
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (done || last_hs_prev) begin
                chk(done == last_hs_prev && !busy, "done_pulse", done, last_hs_prev);
            end
            if (done) begin
                done_flag = 1'b1;
                done_count++;
            end
            last_hs_prev = m_axis_tvalid && m_axis_tready && m_axis_tlast;
            prev_stall   = m_axis_tvalid && !m_axis_tready;
            prev_data    = m_axis_tdata;
            prev_last    = m_axis_tlast;
        end
    end

    task automatic fill_random(input int cm);
        for (int i = 0; i <= cm; i++) mem[i] = $urandom;
    endtask

    task automatic pulse_start(input int cm, input int sh, input logic [18:0] na);
        @(posedge clk);
        #1;
        count_max = FCW'(cm);
        shift     = SW'(sh);
        n_avg     = na;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue_start(input int cm, input int sh, input logic [18:0] na);
        for (int i = 0; i <= cm; i++) begin
            beat_t b;
            b.d = $signed(mem[i]) >>> sh;
            b.l = (i == cm);
            exp_q.push_back(b);
        end
        done_flag    = 1'b0;
        issued       = 0;
        accepted     = 0;
        max_out      = 0;
        beats        = 0;
        max_addr     = 0;
        first_tv_cyc = -1;
        first_hs_cyc = -1;
        last_hs_cyc  = -1;
        pulse_start(cm, sh, na);
    endtask

    task automatic finish_frame(input int cm, input logic [18:0] na, input bit tput);
        int n = 0;
        while (!done_flag && n < cm * 4 + 100) begin
            @(posedge clk);
            n++;
        end
        chk(done_flag, "done_seen", done_flag, 1);
        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        chk(beats == cm + 1, "beat_count", beats, cm + 1);
        chk(n_avg_out == na, "n_avg_out", n_avg_out, na);
        chk(max_out <= FD, "outstanding", max_out, FD);
        if (tput) chk(last_hs_cyc - first_hs_cyc == cm, "throughput", last_hs_cyc - first_hs_cyc, cm);
        exp_q.delete();
    endtask

    task automatic run_frame(input int cm, input int sh, input bit rnd, input bit tput);
        logic [18:0] na;
        na         = 19'($urandom_range(1, 524287));
        rand_ready = rnd;
        issue_start(cm, sh, na);
        finish_frame(cm, na, tput);
    endtask

    initial begin
        logic [18:0] na;
        int          n;
        int          dc;
        rst       = 1'b1;
        start     = 1'b0;
        count_max = '0;
        shift     = '0;
        n_avg     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(n_avg_out == '0, "rst_n_avg_out", n_avg_out, 0);
        chk(bram_en == 1'b0, "rst_bram_en", bram_en, 0);
        chk(bram_addr == '0, "rst_bram_addr", bram_addr, 0);
        chk(m_axis_tvalid == 1'b0, "rst_tvalid", m_axis_tvalid, 0);
        chk(m_axis_tlast == 1'b0, "rst_tlast", m_axis_tlast, 0);
        chk(m_axis_tdata == '0, "rst_tdata", m_axis_tdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) mem[i] = 32'(i * 10);
        run_frame(7, 0, 1'b0, 1'b1);
        chk(first_tv_cyc - start_cyc == RL + 2, "first_latency", first_tv_cyc - start_cyc, RL + 2);

        mem[0] = 32'hFFFF_FC00;
        mem[1] = 32'd1023;
        run_frame(1, 4, 1'b0, 1'b1);

        fill_random(15);
        run_frame(15, $urandom_range(0, 31), 1'b1, 1'b0);

        mem[0] = $urandom;
        run_frame(0, $urandom_range(0, 31), 1'b0, 1'b1);
        mem[0] = $urandom;
        run_frame(0, 3, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int cm;
            cm = $urandom_range(0, 40);
            fill_random(cm);
            run_frame(cm, $urandom_range(0, 31), 1'b1, 1'b0);
        end

        // Start pulsed mid-frame must not change the frame or the latched n_avg.
        fill_random(15);
        rand_ready = 1'b1;
        na = 19'($urandom_range(1, 524287));
        issue_start(15, 1, na);
        n = 0;
        while (beats < 3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        pulse_start(3, 7, ~na);
        finish_frame(15, na, 1'b0);

        // Reset after a few beats abandons the frame with no done.
        fill_random(15);
        rand_ready = 1'b0;
        issue_start(15, 2, 19'd16);
        n = 0;
        while (beats < 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(m_axis_tvalid == 1'b0, "abort_tvalid", m_axis_tvalid, 0);
        chk(busy == 1'b0, "abort_busy", busy, 0);
        chk(bram_en == 1'b0, "abort_bram_en", bram_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dc = done_count;
        exp_q.delete();
        repeat (20) @(posedge clk);
        chk(done_count == dc, "abort_no_done", done_count, dc);
        run_frame(15, 2, 1'b0, 1'b1);

        fill_random(8191);
        run_frame(8191, $urandom_range(0, 31), 1'b0, 1'b1);
        chk(max_addr == 'h7FFC, "max_bram_addr", max_addr, 'h7FFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
